// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// instruction-class codes and the halt opcode.
package seq_pkg;

  localparam int DEF_PC_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] CLS_DP0  = 2'b00;
  localparam logic [1:0] CLS_DP1  = 2'b01;
  localparam logic [1:0] CLS_XFER = 2'b10;
  localparam logic [1:0] CLS_BR   = 2'b11;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  function automatic logic [1:0] instr_class(input logic [8:0] instr);
    return instr[8:7];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog: down-counter reloaded by clear, decremented by enable;
// expired marks the MEM_TIMEOUT-th consecutive enabled cycle.
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count reached while still waiting: this cycle is the last allowed one.
  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer FSM driving fetch/decode/execute/memory/writeback strobes.
// Optional memory-wait timeout is built only when SEQ_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for Start after reset
// FETCH     | IrLoad strobe, instruction register captured
// DECODE    | classify instruction, detect halt opcode
// EXEC      | data processing or branch resolution
// MEM       | MemReq held until MemAck (or watchdog expiry)
// WB        | RegWriteEn strobe, ProgCtr+1
// HALT      | program complete, Done high, Start restarts
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            BranchCond,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            MemAck,
  output logic [PC_W-1:0] ProgCtr,
  output logic            IrLoad,
  output logic            RegWriteEn,
  output logic            MemReq,
  output logic            MemWriteEn,
  output logic            Busy,
  output logic            Done,
  output logic            Err
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic [1:0]      cls;
  logic            start_accept;
  logic            wd_expired;

  assign pc_inc       = pc + PC_W'(1);
  assign cls          = instr_class(Instruction);
  assign start_accept = Start && ((state == ST_IDLE) || (state == ST_HALT));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = '0;
        end
      end
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (Instruction == HALT_INSTR) begin
          state_nxt = ST_HALT;
        end else if (cls == CLS_XFER) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_BR) begin
          state_nxt = ST_FETCH;
          pc_nxt    = BranchCond ? BranchTarget : pc_inc;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        // A completion arriving on the expiry cycle takes priority over the timeout.
        if (MemAck) begin
          if (Instruction[0]) begin
            state_nxt = ST_FETCH;
            pc_nxt    = pc_inc;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (wd_expired) begin
          state_nxt = ST_HALT;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc_inc;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  logic err_q;

  seq_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (state != ST_MEM),
    .enable (state == ST_MEM),
    .expired(wd_expired)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (start_accept) begin
      err_q <= 1'b0;
    end else if ((state == ST_MEM) && !MemAck && wd_expired) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign wd_expired = 1'b0;
  assign Err        = 1'b0;
`endif

  assign ProgCtr    = pc;
  assign IrLoad     = (state == ST_FETCH);
  assign RegWriteEn = (state == ST_WB);
  assign MemReq     = (state == ST_MEM);
  assign MemWriteEn = (state == ST_MEM) && Instruction[0];
  assign Busy       = (state != ST_IDLE) && (state != ST_HALT);
  assign Done       = (state == ST_HALT);

  // start_accept only feeds the error flag; keep it referenced in the default build.
  logic unused_ok;
  assign unused_ok = start_accept;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer against an instruction-level
// reference model (latency, strobes and next ProgCtr per instruction).
module tb_prog_sequencer;

  localparam int PC_W        = 10;
  localparam int MEM_TIMEOUT = 16;
  localparam int PC_MOD      = 1 << PC_W;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic [8:0]      Instruction;
  logic            BranchCond;
  logic [PC_W-1:0] BranchTarget;
  logic            MemAck;
  logic [PC_W-1:0] ProgCtr;
  logic            IrLoad, RegWriteEn, MemReq, MemWriteEn, Busy, Done, Err;

  int checks   = 0;
  int failures = 0;
  int pc_m     = 0;

  prog_sequencer #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .BranchCond(BranchCond), .BranchTarget(BranchTarget), .MemAck(MemAck),
    .ProgCtr(ProgCtr), .IrLoad(IrLoad), .RegWriteEn(RegWriteEn), .MemReq(MemReq),
    .MemWriteEn(MemWriteEn), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge while the sequencer is in IDLE or HALT.
  task automatic do_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    pc_m  = 0;
    check("start_irload", 32'(IrLoad), 1);
    check("start_pc", 32'(ProgCtr), 0);
    check("start_busy", 32'(Busy), 1);
    check("start_done", 32'(Done), 0);
    check("start_err", 32'(Err), 0);
  endtask

  // Called on a falling edge while in FETCH. wt = MemReq cycles before MemAck,
  // negative means MemAck never arrives.
  task automatic run_instr(input logic [8:0] ins, input logic cond,
                           input logic [PC_W-1:0] tgt, input int wt,
                           output logic halted, output int rw_at);
    int n, rw, mrq, mwe_bad;
    int exp_lat, exp_rw, exp_pc, exp_mrq, exp_done, exp_err;
    bit is_mem;
    is_mem   = (ins != 9'h1FF) && (ins[8:7] == 2'b10);
    exp_mrq  = 0;
    exp_done = 0;
    exp_err  = 0;
    if (ins == 9'h1FF) begin
      exp_lat = 2; exp_rw = 0; exp_pc = pc_m; exp_done = 1;
    end else if (is_mem && wt < 0) begin
      exp_lat = 2 + MEM_TIMEOUT; exp_rw = 0; exp_pc = pc_m;
      exp_mrq = MEM_TIMEOUT; exp_done = 1; exp_err = 1;
    end else if (is_mem) begin
      exp_lat = (ins[0] ? 3 : 4) + wt;
      exp_rw  = ins[0] ? 0 : 1;
      exp_pc  = (pc_m + 1) % PC_MOD;
      exp_mrq = wt + 1;
    end else if (ins[8:7] == 2'b11) begin
      exp_lat = 3; exp_rw = 0;
      exp_pc  = cond ? int'(tgt) : (pc_m + 1) % PC_MOD;
    end else begin
      exp_lat = 4; exp_rw = 1; exp_pc = (pc_m + 1) % PC_MOD;
    end

    Instruction  = ins;
    BranchCond   = cond;
    BranchTarget = tgt;
    MemAck       = 1'b0;
    Start        = 1'($urandom_range(0, 1));
    n = 0; rw = 0; mrq = 0; mwe_bad = 0; rw_at = -1;
    forever begin
      @(negedge Clk);
      n++;
      if (RegWriteEn) begin
        rw++;
        if (rw_at < 0) rw_at = n;
      end
      if (MemReq) begin
        mrq++;
        if (MemWriteEn !== ins[0]) mwe_bad++;
      end
      if (IrLoad || Done || n > 200) break;
      if (MemReq) MemAck = (wt >= 0) && (mrq == wt + 1);
      else        MemAck = 1'($urandom_range(0, 1));
      Start = Busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    MemAck = 1'b0;
    Start  = 1'b0;
    check("bounded_wait", 32'(n <= 200), 1);
    check("latency", 32'(n), 32'(exp_lat));
    check("regwrite_count", 32'(rw), 32'(exp_rw));
    check("memreq_cycles", 32'(mrq), 32'(exp_mrq));
    check("memwriteen_qual", 32'(mwe_bad), 0);
    check("pc", 32'(ProgCtr), 32'(exp_pc));
    check("done", 32'(Done), 32'(exp_done));
    check("busy", 32'(Busy), 32'(!exp_done));
    check("err", 32'(Err), 32'(exp_err));
    pc_m   = exp_pc;
    halted = Done;
  endtask

  logic halted;
  int   rw_at;
  logic [8:0] ins;

  initial begin
    Reset = 1'b1; Start = 1'b0; Instruction = 9'h0; BranchCond = 1'b0;
    BranchTarget = '0; MemAck = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_pc", 32'(ProgCtr), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_irload", 32'(IrLoad), 0);
    check("rst_memreq", 32'(MemReq), 0);
    check("rst_err", 32'(Err), 0);
    Reset = 1'b0;
    do_start();

    run_instr(9'h005, 1'b0, '0, 0, halted, rw_at);
    check("dp_rw_cycle", 32'(rw_at), 3);
    run_instr(9'h180, 1'b1, 10'h2A, 0, halted, rw_at);
    run_instr(9'h180, 1'b0, 10'h3C, 0, halted, rw_at);
    run_instr(9'h100, 1'b0, '0, 3, halted, rw_at);
    run_instr(9'h101, 1'b0, '0, 3, halted, rw_at);
    run_instr(9'h180, 1'b1, 10'h3FF, 0, halted, rw_at);
    run_instr(9'h1FF, 1'b0, '0, 0, halted, rw_at);
    repeat (3) @(negedge Clk);
    check("halt_hold_pc", 32'(ProgCtr), 32'h3FF);
    check("halt_hold_done", 32'(Done), 1);
    do_start();
    run_instr(9'h180, 1'b1, 10'h3FF, 0, halted, rw_at);
    run_instr(9'h000, 1'b0, '0, 0, halted, rw_at);
    check("wrap_pc", 32'(ProgCtr), 0);

    // Reset in the middle of a memory wait.
    run_instr(9'h1C0, 1'b1, 10'h155, 0, halted, rw_at);
    Instruction = 9'h100;
    @(negedge Clk);
    @(negedge Clk);
    check("pre_rst_memreq", 32'(MemReq), 1);
    #2 Reset = 1'b1;
    #1;
    check("midmem_rst_memreq", 32'(MemReq), 0);
    check("midmem_rst_busy", 32'(Busy), 0);
    check("midmem_rst_pc", 32'(ProgCtr), 0);
    @(negedge Clk);
    Reset = 1'b0;
    do_start();

`ifdef SEQ_TIMEOUT_EN
    run_instr(9'h100, 1'b0, '0, -1, halted, rw_at);
    do_start();
    run_instr(9'h101, 1'b0, '0, MEM_TIMEOUT - 1, halted, rw_at);
    run_instr(9'h100, 1'b0, '0, MEM_TIMEOUT - 1, halted, rw_at);
`endif

    for (int i = 0; i < 150; i++) begin
      ins = 9'($urandom_range(0, 510));
      if ($urandom_range(0, 24) == 0) ins = 9'h1FF;
      run_instr(ins, 1'($urandom_range(0, 1)), PC_W'($urandom_range(0, PC_MOD - 1)),
                $urandom_range(0, 6), halted, rw_at);
      if (halted) begin
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        do_start();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
